// File: rtl/alu_seq_if.sv
// alu_seq_if: control-unit <-> execution-unit handshake and operand bus.
// The master drives the request and operands; the slave (alu_seq) returns
// busy/done/err, the registered result and the flags.
interface alu_seq_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start_i;
  logic [3:0]            op_i;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic                  carry_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  flag_zero_o;
  logic                  flag_negative_o;
  logic                  flag_carry_o;

  modport master (
    output start_i, op_i, a_i, b_i, carry_i,
    input  busy_o, done_o, err_o, result_o,
    input  flag_zero_o, flag_negative_o, flag_carry_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, carry_i,
    output busy_o, done_o, err_o, result_o,
    output flag_zero_o, flag_negative_o, flag_carry_o
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential execution unit for the SAP-2 datapath.
// Logic and add/sub ops complete in one cycle; shifts/rotates by k >= 1 take
// one EXEC cycle per bit. Optional iterative multiply (op 12) is enabled by
// defining ALU_SEQ_MUL_EN; without it op 12 is treated as an illegal opcode.
// Reset is asserted asynchronously and released through a two-flop
// synchroniser so every state register leaves reset on the same edge.
module alu_seq #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHAMT_WIDTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);

  localparam int W = DATA_WIDTH;
`ifdef ALU_SEQ_MUL_EN
  // Counter must hold DATA_WIDTH for the multiply.
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
`else
  localparam int CNT_W = SHAMT_WIDTH;
`endif

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_NOT = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_ADC = 4'd6;
  localparam logic [3:0] OP_SBC = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_ROR = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [1:0]             rst_sync_q;
  logic                   rst_n;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [W-1:0]           work_q;
  logic [1:0]             shop_q;
  logic [W-1:0]           result_q;
  logic                   z_q;
  logic                   n_q;
  logic                   c_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;

  logic [SHAMT_WIDTH-1:0] shamt_s;
  logic [W:0]             arith_s;
  logic [W-1:0]           sc_res_s;
  logic                   sc_c_s;
  logic                   sc_illegal_s;
  logic                   sc_iter_s;
  logic [W-1:0]           step_w_s;
  logic                   step_c_s;
  logic [W-1:0]           fin_w_s;
  logic                   fin_c_s;

`ifdef ALU_SEQ_MUL_EN
  logic                   mul_q;
  logic [W-1:0]           mcand_q;
  logic [W-1:0]           mhi_q;
  logic [W:0]             mul_sum_s;
  logic [W-1:0]           mul_hi_s;
  logic [W-1:0]           mul_lo_s;
`endif

  assign shamt_s = bus.b_i[SHAMT_WIDTH-1:0];

  // Reset synchroniser: asynchronous assertion, release on the second edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // Single-cycle result/carry and classification of the requested opcode.
  always_comb begin
    arith_s      = {(W+1){1'b0}};
    sc_res_s     = bus.a_i;
    sc_c_s       = 1'b0;
    sc_illegal_s = 1'b0;
    sc_iter_s    = 1'b0;
    case (bus.op_i)
      OP_AND: sc_res_s = bus.a_i & bus.b_i;
      OP_OR:  sc_res_s = bus.a_i | bus.b_i;
      OP_XOR: sc_res_s = bus.a_i ^ bus.b_i;
      OP_NOT: sc_res_s = ~bus.a_i;
      OP_ADD: begin
        arith_s  = {1'b0, bus.a_i} + {1'b0, bus.b_i};
        sc_res_s = arith_s[W-1:0];
        sc_c_s   = arith_s[W];
      end
      OP_SUB: begin
        arith_s  = {1'b0, bus.a_i} - {1'b0, bus.b_i};
        sc_res_s = arith_s[W-1:0];
        sc_c_s   = arith_s[W];
      end
      OP_ADC: begin
        arith_s  = {1'b0, bus.a_i} + {1'b0, bus.b_i} + {{W{1'b0}}, bus.carry_i};
        sc_res_s = arith_s[W-1:0];
        sc_c_s   = arith_s[W];
      end
      OP_SBC: begin
        arith_s  = {1'b0, bus.a_i} - {1'b0, bus.b_i} - {{W{1'b0}}, bus.carry_i};
        sc_res_s = arith_s[W-1:0];
        sc_c_s   = arith_s[W];
      end
      // A zero shift amount finishes at once with result = A and C = 0.
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: sc_iter_s = (shamt_s != {SHAMT_WIDTH{1'b0}});
      OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        sc_iter_s    = 1'b1;
`else
        sc_illegal_s = 1'b1;
`endif
      end
      default: sc_illegal_s = 1'b1;
    endcase
  end

  // One iteration step: single-bit shift/rotate, or one shift-add partial product.
  always_comb begin
    step_w_s = work_q;
    step_c_s = 1'b0;
    case (shop_q)
      2'd0: begin
        step_w_s = {work_q[W-2:0], 1'b0};
        step_c_s = work_q[W-1];
      end
      2'd1: begin
        step_w_s = {1'b0, work_q[W-1:1]};
        step_c_s = work_q[0];
      end
      2'd2: begin
        step_w_s = {work_q[W-2:0], work_q[W-1]};
        step_c_s = work_q[W-1];
      end
      2'd3: begin
        step_w_s = {work_q[0], work_q[W-1:1]};
        step_c_s = work_q[0];
      end
      default: begin
        step_w_s = work_q;
        step_c_s = 1'b0;
      end
    endcase
`ifdef ALU_SEQ_MUL_EN
    // work_q holds the multiplier shifting right; its low bit gates the add.
    mul_sum_s = {1'b0, mhi_q} + (work_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    mul_hi_s  = mul_sum_s[W:1];
    mul_lo_s  = {mul_sum_s[0], work_q[W-1:1]};
    if (mul_q) begin
      fin_w_s = mul_lo_s;
      fin_c_s = |mul_hi_s;
    end else begin
      fin_w_s = step_w_s;
      fin_c_s = step_c_s;
    end
`else
    fin_w_s = step_w_s;
    fin_c_s = step_c_s;
`endif
  end

  // Control FSM with registered handshake, result and flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      work_q   <= {W{1'b0}};
      shop_q   <= 2'd0;
      result_q <= {W{1'b0}};
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mul_q    <= 1'b0;
      mcand_q  <= {W{1'b0}};
      mhi_q    <= {W{1'b0}};
`endif
    end else begin
      case (state_q)
        // DONE accepts a new request exactly like IDLE (back-to-back issue).
        ST_IDLE, ST_DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (bus.start_i) begin
            if (sc_iter_s) begin
              work_q  <= bus.a_i;
              shop_q  <= bus.op_i[1:0];
              busy_q  <= 1'b1;
              state_q <= ST_EXEC;
`ifdef ALU_SEQ_MUL_EN
              mul_q   <= (bus.op_i == OP_MUL);
              mcand_q <= bus.a_i;
              mhi_q   <= {W{1'b0}};
              if (bus.op_i == OP_MUL) begin
                work_q <= bus.b_i;
                cnt_q  <= CNT_W'(W);
              end else begin
                cnt_q  <= CNT_W'(shamt_s);
              end
`else
              cnt_q   <= shamt_s;
`endif
            end else begin
              result_q <= sc_res_s;
              err_q    <= sc_illegal_s;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
              // An illegal opcode passes A through but leaves the flags alone.
              if (!sc_illegal_s) begin
                z_q <= (sc_res_s == {W{1'b0}});
                n_q <= sc_res_s[W-1];
                c_q <= sc_c_s;
              end else begin
                z_q <= z_q;
                n_q <= n_q;
                c_q <= c_q;
              end
            end
          end
        end
        ST_EXEC: begin
          cnt_q  <= cnt_q - CNT_W'(1);
          work_q <= fin_w_s;
`ifdef ALU_SEQ_MUL_EN
          mhi_q  <= mul_hi_s;
`endif
          if (cnt_q == CNT_W'(1)) begin
            result_q <= fin_w_s;
            z_q      <= (fin_w_s == {W{1'b0}});
            n_q      <= fin_w_s[W-1];
            c_q      <= fin_c_s;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            state_q  <= ST_EXEC;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o          = busy_q;
  assign bus.done_o          = done_q;
  assign bus.err_o           = err_q;
  assign bus.result_o        = result_q;
  assign bus.flag_zero_o     = z_q;
  assign bus.flag_negative_o = n_q;
  assign bus.flag_carry_o    = c_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed test-plan steps followed by randomized operations,
// checked against an arithmetic reference model of the opcode rules.
module tb_alu_seq;
  localparam int W = 8;
  localparam int S = 3;

  logic clk = 1'b0;
  logic reset;

  alu_seq_if #(.DATA_WIDTH(W)) bus ();

  alu_seq #(.DATA_WIDTH(W), .SHAMT_WIDTH(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model view of the registered outputs.
  logic [W-1:0] m_res;
  logic         m_z, m_n, m_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: result, carry, illegal flag and done latency (cycles after start).
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, output logic [W-1:0] res, output logic c,
                                output logic err, output int lat);
    longint unsigned ua, ub, full;
    int k;
    ua  = a;
    ub  = b;
    k   = int'(ub % (64'd1 << S));
    res = a;
    c   = 1'b0;
    err = 1'b0;
    lat = 1;
    case (op)
      4'd0: res = a & b;
      4'd1: res = a | b;
      4'd2: res = a ^ b;
      4'd3: res = ~a;
      4'd4: begin full = ua + ub;       res = W'(full); c = ((full >> W) & 1) != 0; end
      4'd5: begin res = W'(ua - ub);       c = (ua < ub); end
      4'd6: begin full = ua + ub + cin; res = W'(full); c = ((full >> W) & 1) != 0; end
      4'd7: begin res = W'(ua - ub - cin); c = (ua < ub + cin); end
      4'd8: if (k > 0) begin res = W'(ua << k); c = ((ua >> (W - k)) & 1) != 0; lat = k + 1; end
      4'd9: if (k > 0) begin res = W'(ua >> k); c = ((ua >> (k - 1)) & 1) != 0; lat = k + 1; end
      4'd10: if (k > 0) begin
        full = (ua << k) | (ua >> (W - k)); res = W'(full); c = res[0]; lat = k + 1;
      end
      4'd11: if (k > 0) begin
        full = (ua >> k) | (ua << (W - k)); res = W'(full); c = res[W-1]; lat = k + 1;
      end
`ifdef ALU_SEQ_MUL_EN
      4'd12: begin full = ua * ub; res = W'(full); c = (full >> W) != 0; lat = W + 1; end
`endif
      default: err = 1'b1;
    endcase
  endfunction

  // Issue one op at the current negedge and check the completion.
  // scramble: keep requesting random ops while the unit should be busy.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input bit scramble, input string tag);
    logic [W-1:0] e_res;
    logic         e_c, e_err;
    int           e_lat, lat, busy_n;
    model(op, a, b, cin, e_res, e_c, e_err, e_lat);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.carry_i = cin;
    @(negedge clk);
    bus.start_i = 1'b0;
    lat    = 1;
    busy_n = 0;
    while (bus.done_o !== 1'b1 && lat < 40) begin
      if (bus.busy_o === 1'b1) busy_n++;
      chk({tag, " hold"}, 32'(bus.result_o), 32'(m_res));
      if (scramble && lat < e_lat) begin
        bus.start_i = 1'b1;
        bus.op_i    = 4'($urandom_range(0, 15));
        bus.a_i     = W'($urandom);
        bus.b_i     = W'($urandom);
        bus.carry_i = 1'($urandom);
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start_i = 1'b0;
    m_res = e_res;
    if (!e_err) begin
      m_z = (e_res == '0);
      m_n = e_res[W-1];
      m_c = e_c;
    end
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'(e_lat - 1));
    chk({tag, " busy_at_done"}, 32'(bus.busy_o), 32'd0);
    chk({tag, " err"}, 32'(bus.err_o), 32'(e_err));
    chk({tag, " result"}, 32'(bus.result_o), 32'(m_res));
    chk({tag, " z"}, 32'(bus.flag_zero_o), 32'(m_z));
    chk({tag, " n"}, 32'(bus.flag_negative_o), 32'(m_n));
    chk({tag, " c"}, 32'(bus.flag_carry_o), 32'(m_c));
  endtask

  // One cycle after a completion with no new request: pulse must be gone.
  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(bus.done_o), 32'd0);
    chk({tag, " idle_busy"}, 32'(bus.busy_o), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " result"}, 32'(bus.result_o), 32'd0);
    chk({tag, " flags"}, 32'({bus.flag_zero_o, bus.flag_negative_o, bus.flag_carry_o}), 32'd0);
    chk({tag, " busy"}, 32'(bus.busy_o), 32'd0);
    chk({tag, " done"}, 32'(bus.done_o), 32'd0);
    chk({tag, " err"}, 32'(bus.err_o), 32'd0);
  endtask

  initial begin
    reset       = 1'b0;
    bus.start_i = 1'b0;
    bus.op_i    = 4'd0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.carry_i = 1'b0;
    m_res = '0;
    m_z   = 1'b0;
    m_n   = 1'b0;
    m_c   = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // OR F0|05
    do_op(4'd1, 8'hF0, 8'h05, 1'b0, 1'b0, "or");
    chk("or const", 32'(bus.result_o), 32'h0000_00F5);
    idle_check("or");

    // ADD FF+01, then SUB 05-06 issued in the DONE cycle
    do_op(4'd4, 8'hFF, 8'h01, 1'b0, 1'b0, "add");
    chk("add const zc", 32'({bus.flag_zero_o, bus.flag_carry_o}), 32'd3);
    do_op(4'd5, 8'h05, 8'h06, 1'b0, 1'b0, "sub_b2b");
    chk("sub const", 32'(bus.result_o), 32'h0000_00FF);
    idle_check("sub");

    // SHL 81 by 3 with ignored starts while busy
    do_op(4'd8, 8'h81, 8'h03, 1'b0, 1'b1, "shl");
    chk("shl const", 32'(bus.result_o), 32'h0000_0008);
    idle_check("shl");
    chk("shl stable", 32'(bus.result_o), 32'h0000_0008);

    // ROR by 0 and by 1
    do_op(4'd11, 8'h01, 8'h00, 1'b0, 1'b0, "ror0");
    idle_check("ror0");
    do_op(4'd11, 8'h01, 8'h01, 1'b0, 1'b0, "ror1");
    chk("ror1 const", 32'(bus.result_o), 32'h0000_0080);
    idle_check("ror1");

    // Reset during EXEC of SHL k=5
    bus.start_i = 1'b1;
    bus.op_i    = 4'd8;
    bus.a_i     = 8'h3C;
    bus.b_i     = 8'h05;
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("pre_reset busy", 32'(bus.busy_o), 32'd1);
    #2 reset = 1'b0;
    #1 chk_zero("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    m_res = '0;
    m_z   = 1'b0;
    m_n   = 1'b0;
    m_c   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_reset no_done", 32'(bus.done_o), 32'd0);
    end
    do_op(4'd1, 8'h12, 8'h40, 1'b0, 1'b0, "or_after_reset");
    idle_check("or_after_reset");

    // MUL 10*11 (latency/err depend on build, result 10 either way)
    do_op(4'd12, 8'h10, 8'h11, 1'b0, 1'b0, "mul");
    chk("mul const", 32'(bus.result_o), 32'h0000_0010);
    idle_check("mul");

    // Randomized ops, mixing back-to-back issue and idle gaps
    for (int i = 0; i < 250; i++) begin
      logic [3:0]   r_op;
      logic [W-1:0] r_a, r_b;
      logic         r_c;
      bit           r_scr;
      r_op  = 4'($urandom_range(0, 15));
      r_a   = W'($urandom);
      r_b   = W'($urandom);
      r_c   = 1'($urandom);
      r_scr = 1'($urandom);
      do_op(r_op, r_a, r_b, r_c, r_scr, "rand");
      if ($urandom_range(0, 1) == 1) idle_check("rand");
    end
    idle_check("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
